sap_run_ctrl: RTL
=================

Name: sap_run_ctrl

Overview:
- Run/load controller that sequences the SAP-style `computer` core.
- Holds the core in reset while a program is written into its RAM over a valid/ready port.
- Generates the core's clock-enable (`i_clke`) for free-run at a divided rate, or for single-step.
- Detects the core's halt and counts executed clock-enable pulses. Sits between the test harness/front panel and the core, replacing the constant `i_clke`.

Parameters:
- DATA_WIDTH, 8, core data / RAM word width
- ADDR_WIDTH, 4, core RAM address width
- DIV_WIDTH, 8, width of the clock-enable divider
- CYC_WIDTH, 16, width of the clke pulse counter

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_load_valid  in  1  program write request
- i_load_addr  in  ADDR_WIDTH  program write address
- i_load_data  in  DATA_WIDTH  program write data
- o_load_ready  out  1  write accepted when valid&ready
- i_start  in  1  begin/resume free-run
- i_step  in  1  single-step request
- i_stop  in  1  pause run / return to idle
- i_div  in  DIV_WIDTH  free-run divide: clke every i_div+1 cycles
- i_halt  in  1  core halt flag (o_halt of core)
- o_cpu_reset  out  1  reset to core
- o_clke  out  1  clock-enable to core
- o_prog_we  out  1  RAM write strobe to core
- o_prog_addr  out  ADDR_WIDTH  RAM write address
- o_prog_data  out  DATA_WIDTH  RAM write data
- o_state  out  2  IDLE=0, RUN=1, PAUSE=2, HALTED=3
- o_cycles  out  CYC_WIDTH  clke pulses issued since leaving IDLE
- o_done  out  1  state==HALTED

Behaviour:
- Reset (async, active-high):
  - state IDLE, o_cpu_reset=1, o_clke=0, o_prog_we=0, o_prog_addr=0, o_prog_data=0, o_cycles=0, divider count=0, div_q=0.
- All outputs are registered except:
  - o_load_ready = (state==IDLE).
  - o_done is decoded from state.
- Command priority per cycle: stop > start > step.
- IDLE:
  - o_cpu_reset=1.
  - Load handshake: valid&ready registers addr/data and pulses o_prog_we for exactly one cycle (latency 1). Back-to-back writes are allowed every cycle.
  - i_start → RUN. i_step (without start) → PAUSE. Both:
    - drop o_cpu_reset;
    - clear o_cycles and the divider count;
    - latch i_div into div_q.
  - A load beat in the same cycle as start/step is still performed.
- RUN:
  - Divider count increments each cycle.
  - When count==div_q: o_clke=1 for one cycle, count←0. Otherwise o_clke=0.
  - div_q=0 gives clke every cycle. The first pulse occurs div_q+1 cycles after entry.
  - i_halt=1 → HALTED; no clke is issued that cycle and none after.
  - i_stop → PAUSE; count is preserved, o_clke=0.
- PAUSE:
  - Each cycle with i_step=1 (and i_halt=0) gives o_clke=1 next cycle; a held step yields one pulse per cycle.
  - i_start → RUN, resuming with the preserved count.
  - i_stop → IDLE, which reasserts o_cpu_reset.
  - i_halt=1 → HALTED, step ignored.
- HALTED:
  - o_clke=0, o_cpu_reset=0 (core state stays visible).
  - i_stop → IDLE. i_start and i_step are ignored.
- o_cycles:
  - +1 on every issued clke pulse.
  - Saturates at all-ones (no wrap).
  - Holds its value in HALTED/IDLE until the next IDLE exit.
- i_load_valid outside IDLE is not accepted and no write is generated. A requester must hold valid until ready.
- i_div changes outside IDLE exit have no effect until the next IDLE exit.
- Reset mid-RUN: clke drops immediately (async), core is reset, state IDLE, program RAM contents untouched by this block.

Test Plan:
- Reset, then load 16 words addr k data 8'hE0+k with valid held 16 cycles → 16 single-cycle o_prog_we pulses with matching addr/data, o_cpu_reset=1 throughout, o_state=0.
- i_div=3, pulse i_start → o_cpu_reset falls next edge; o_clke high on cycles 4, 8, 12 after entry; o_cycles=3 after 12 cycles.
- RUN with i_div=0, raise i_halt after 5 pulses → o_clke never asserted in or after the halt cycle, o_state=3, o_done=1, o_cycles=5.
- RUN, pulse i_stop, then three 1-cycle i_step pulses → o_state=2, exactly 3 o_clke pulses, each one cycle after its step; then i_start resumes RUN.
- Same cycle i_stop=i_start=i_step=1 in PAUSE → IDLE (stop wins), o_cpu_reset=1; i_load_valid during RUN/HALTED → o_load_ready=0, no o_prog_we.
- Assert i_reset asynchronously mid-RUN while o_clke=1 → o_clke=0 and o_cpu_reset=1 before next clock edge; o_cycles=0; o_cycles saturation checked with CYC_WIDTH=4, i_div=0: stays 15 after 20 pulses.

Source files
------------

// File: rtl/sap_run_ctrl.sv
// ============================================================================
// Module   : sap_run_ctrl
// Purpose  : Load / run / single-step / halt sequencer driving the clock
//            enable and reset of a SAP-style core.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sap_run_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DIV_WIDTH  = 8,
   parameter int CYC_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_load_valid,
   input  logic [ADDR_WIDTH-1:0] i_load_addr,
   input  logic [DATA_WIDTH-1:0] i_load_data,
   output logic                  o_load_ready,
   input  logic                  i_start,
   input  logic                  i_step,
   input  logic                  i_stop,
   input  logic [DIV_WIDTH-1:0]  i_div,
   input  logic                  i_halt,
   output logic                  o_cpu_reset,
   output logic                  o_clke,
   output logic                  o_prog_we,
   output logic [ADDR_WIDTH-1:0] o_prog_addr,
   output logic [DATA_WIDTH-1:0] o_prog_data,
   output logic [1:0]            o_state,
   output logic [CYC_WIDTH-1:0]  o_cycles,
   output logic                  o_done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_PAUSE  = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   localparam logic [CYC_WIDTH-1:0] c_CYC_ONE = {{(CYC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DIV_WIDTH-1:0] c_DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            r_state;
   logic                  r_cpu_reset;
   logic                  r_clke;
   logic                  r_prog_we;
   logic [ADDR_WIDTH-1:0] r_prog_addr;
   logic [DATA_WIDTH-1:0] r_prog_data;
   logic [CYC_WIDTH-1:0]  r_cycles;
   logic [DIV_WIDTH-1:0]  r_div_cnt;
   logic [DIV_WIDTH-1:0]  r_div_q;
   logic [CYC_WIDTH-1:0]  w_cycles_inc;

   // Pulse counter saturates so long runs never alias back to small values.
   assign w_cycles_inc = (&r_cycles) ? r_cycles : (r_cycles + c_CYC_ONE);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cpu_reset <= 1'b1;
         r_clke      <= 1'b0;
         r_prog_we   <= 1'b0;
         r_prog_addr <= '0;
         r_prog_data <= '0;
         r_cycles    <= '0;
         r_div_cnt   <= '0;
         r_div_q     <= '0;
      end else begin
         r_prog_we <= 1'b0;
         r_clke    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_load_valid) begin
                  r_prog_we   <= 1'b1;
                  r_prog_addr <= i_load_addr;
                  r_prog_data <= i_load_data;
               end
               if (!i_stop && (i_start || i_step)) begin
                  r_state     <= i_start ? S_RUN : S_PAUSE;
                  r_cpu_reset <= 1'b0;
                  r_cycles    <= '0;
                  r_div_cnt   <= '0;
                  r_div_q     <= i_div;
               end
            end
            S_RUN: begin
               if (i_stop) begin
                  r_state <= S_PAUSE;
               end else if (i_halt) begin
                  r_state <= S_HALTED;
               end else if (r_div_cnt == r_div_q) begin
                  r_clke    <= 1'b1;
                  r_cycles  <= w_cycles_inc;
                  r_div_cnt <= '0;
               end else begin
                  r_div_cnt <= r_div_cnt + c_DIV_ONE;
               end
            end
            S_PAUSE: begin
               // The divider count is left untouched so a resumed run keeps its phase.
               if (i_stop) begin
                  r_state     <= S_IDLE;
                  r_cpu_reset <= 1'b1;
               end else if (i_halt) begin
                  r_state <= S_HALTED;
               end else if (i_start) begin
                  r_state <= S_RUN;
               end else if (i_step) begin
                  r_clke   <= 1'b1;
                  r_cycles <= w_cycles_inc;
               end
            end
            S_HALTED: begin
               if (i_stop) begin
                  r_state     <= S_IDLE;
                  r_cpu_reset <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cpu_reset <= 1'b1;
            end
         endcase
      end
   end

   assign o_load_ready = (r_state == S_IDLE);
   assign o_done       = (r_state == S_HALTED);
   assign o_state      = r_state;
   assign o_cpu_reset  = r_cpu_reset;
   assign o_clke       = r_clke;
   assign o_prog_we    = r_prog_we;
   assign o_prog_addr  = r_prog_addr;
   assign o_prog_data  = r_prog_data;
   assign o_cycles     = r_cycles;

endmodule

`default_nettype wire
